// File: rtl/wb_register_file.sv
// Writeback stage: picks memory or execution data, commits it to the integer register file,
// serves two asynchronous read ports with optional same-cycle bypass, and counts commits.
module wb_register_file #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned REG_COUNT     = 32,
  parameter int unsigned COUNTER_WIDTH = 64,
  parameter bit          WRITE_BYPASS  = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [XLEN-1:0]          wbMemoryData,
  input  logic [XLEN-1:0]          wbExecutionData,
  input  logic [4:0]               wbWriteRegisterIndex,
  input  logic                     wbMemToReg,
  input  logic                     wbRegWrite,
  input  logic [4:0]               readRegisterIndex1,
  input  logic [4:0]               readRegisterIndex2,
  output logic [XLEN-1:0]          readData1,
  output logic [XLEN-1:0]          readData2,
  output logic [XLEN-1:0]          wbWriteData,
  output logic [COUNTER_WIDTH-1:0] writebackCount
);

  logic [XLEN-1:0]          regs_q [REG_COUNT];
  logic [XLEN-1:0]          regs_d [REG_COUNT];
  logic [COUNTER_WIDTH-1:0] count_q, count_d;
  logic                     commit;

  always_comb begin
    wbWriteData = wbMemToReg ? wbMemoryData : wbExecutionData;
  end

  // Reset blocks the commit, which also suppresses bypass during the reset cycle.
  always_comb begin
    commit = wbRegWrite && (wbWriteRegisterIndex != 5'd0) && !reset;
  end

  always_comb begin
    regs_d  = regs_q;
    count_d = count_q;
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_d[i] = '0;
      end
      count_d = '0;
    end else if (commit) begin
      regs_d[wbWriteRegisterIndex] = wbWriteData;
      count_d = count_q + COUNTER_WIDTH'(1);
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    regs_q  <= regs_d;
    count_q <= count_d;
  end

  function automatic logic [XLEN-1:0] read_port(
    input logic [4:0]      idx,
    input logic            wr_en,
    input logic [4:0]      wr_idx,
    input logic [XLEN-1:0] wr_data,
    input logic [XLEN-1:0] stored
  );
    logic [XLEN-1:0] result;
    if (idx == 5'd0) begin
      result = '0;
    end else if (WRITE_BYPASS && wr_en && (idx == wr_idx)) begin
      result = wr_data;
    end else begin
      result = stored;
    end
    return result;
  endfunction

  always_comb begin
    readData1 = read_port(readRegisterIndex1, commit, wbWriteRegisterIndex, wbWriteData,
                          regs_q[readRegisterIndex1]);
    readData2 = read_port(readRegisterIndex2, commit, wbWriteRegisterIndex, wbWriteData,
                          regs_q[readRegisterIndex2]);
  end

  always_comb begin
    writebackCount = count_q;
  end

endmodule

// File: tb/tb_wb_register_file.sv
// Directed bench for wb_register_file: default build, a no-bypass build and a 4-bit counter
// build share one stimulus stream; expectations go through a scoreboard queue.
module tb_wb_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_data, exe_data;
  logic [4:0]  wr_idx, rd_idx1, rd_idx2;
  logic        mem_to_reg, reg_write;

  logic [31:0] rd1_a, rd2_a, wbd_a;
  logic [63:0] cnt_a;
  logic [31:0] rd1_n, rd2_n, wbd_n;
  logic [63:0] cnt_n;
  logic [31:0] rd1_c, rd2_c, wbd_c;
  logic [3:0]  cnt_c;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_register_file dut (
    .clk(clk), .reset(reset), .wbMemoryData(mem_data), .wbExecutionData(exe_data),
    .wbWriteRegisterIndex(wr_idx), .wbMemToReg(mem_to_reg), .wbRegWrite(reg_write),
    .readRegisterIndex1(rd_idx1), .readRegisterIndex2(rd_idx2),
    .readData1(rd1_a), .readData2(rd2_a), .wbWriteData(wbd_a), .writebackCount(cnt_a)
  );

  wb_register_file #(.WRITE_BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .wbMemoryData(mem_data), .wbExecutionData(exe_data),
    .wbWriteRegisterIndex(wr_idx), .wbMemToReg(mem_to_reg), .wbRegWrite(reg_write),
    .readRegisterIndex1(rd_idx1), .readRegisterIndex2(rd_idx2),
    .readData1(rd1_n), .readData2(rd2_n), .wbWriteData(wbd_n), .writebackCount(cnt_n)
  );

  wb_register_file #(.COUNTER_WIDTH(4)) dut_c4 (
    .clk(clk), .reset(reset), .wbMemoryData(mem_data), .wbExecutionData(exe_data),
    .wbWriteRegisterIndex(wr_idx), .wbMemToReg(mem_to_reg), .wbRegWrite(reg_write),
    .readRegisterIndex1(rd_idx1), .readRegisterIndex2(rd_idx2),
    .readData1(rd1_c), .readData2(rd2_c), .wbWriteData(wbd_c), .writebackCount(cnt_c)
  );

  task automatic expect_val(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h expected <none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, checks follow #1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_data = '0; exe_data = '0; wr_idx = '0;
    rd_idx1 = '0; rd_idx2 = '0; mem_to_reg = 1'b0; reg_write = 1'b0;
    tick();
    reset = 1'b0;

    // Sweep every index on both ports after reset.
    for (int i = 0; i < 32; i++) begin
      rd_idx1 = 5'(i);
      rd_idx2 = 5'(31 - i);
      expect_val($sformatf("reset_rd1_%0d", i), 64'd0);
      expect_val($sformatf("reset_rd2_%0d", 31 - i), 64'd0);
      expect_val($sformatf("reset_nb_rd1_%0d", i), 64'd0);
      #1;
      check({32'd0, rd1_a});
      check({32'd0, rd2_a});
      check({32'd0, rd1_n});
      tick();
    end
    expect_val("reset_count", 64'd0);
    expect_val("reset_count_c4", 64'd0);
    #1;
    check(cnt_a);
    check({60'd0, cnt_c});
    tick();

    // Execution-data write to x5.
    reg_write = 1'b1; wr_idx = 5'd5; mem_to_reg = 1'b0; exe_data = 32'hDEADBEEF;
    expect_val("exe_select", 64'hDEADBEEF);
    #1;
    check({32'd0, wbd_a});
    tick();
    reg_write = 1'b0; rd_idx1 = 5'd5;
    expect_val("x5_after_write", 64'hDEADBEEF);
    expect_val("count_after_x5", 64'd1);
    #1;
    check({32'd0, rd1_a});
    check(cnt_a);
    tick();

    // Memory-data write to x7; no-bypass build still shows the old value before the edge.
    reg_write = 1'b1; wr_idx = 5'd7; mem_to_reg = 1'b1;
    mem_data = 32'h12345678; exe_data = 32'hFFFFFFFF; rd_idx1 = 5'd7;
    expect_val("mem_select", 64'h12345678);
    expect_val("x7_bypass", 64'h12345678);
    expect_val("x7_nb_before", 64'd0);
    #1;
    check({32'd0, wbd_a});
    check({32'd0, rd1_a});
    check({32'd0, rd1_n});
    tick();
    reg_write = 1'b0;
    expect_val("x7_nb_after", 64'h12345678);
    expect_val("count_after_x7", 64'd2);
    #1;
    check({32'd0, rd1_n});
    check(cnt_a);
    tick();

    // Write to x0 is dropped and not counted.
    reg_write = 1'b1; wr_idx = 5'd0; mem_to_reg = 1'b0; exe_data = 32'hAAAA5555; rd_idx1 = 5'd0;
    expect_val("x0_during_write", 64'd0);
    #1;
    check({32'd0, rd1_a});
    tick();
    reg_write = 1'b0;
    expect_val("x0_after_write", 64'd0);
    expect_val("count_after_x0", 64'd2);
    #1;
    check({32'd0, rd1_a});
    check(cnt_a);
    tick();

    // Bypass on both ports: x3 = 1, then same-cycle write of 2.
    reg_write = 1'b1; wr_idx = 5'd3; exe_data = 32'h1;
    tick();
    exe_data = 32'h2; rd_idx1 = 5'd3; rd_idx2 = 5'd3;
    expect_val("bypass_rd1", 64'h2);
    expect_val("bypass_rd2", 64'h2);
    expect_val("nb_rd1_old", 64'h1);
    expect_val("nb_rd2_old", 64'h1);
    #1;
    check({32'd0, rd1_a});
    check({32'd0, rd2_a});
    check({32'd0, rd1_n});
    check({32'd0, rd2_n});
    tick();
    reg_write = 1'b0;
    expect_val("nb_rd1_new", 64'h2);
    expect_val("nb_rd2_new", 64'h2);
    expect_val("count_after_x3", 64'd4);
    #1;
    check({32'd0, rd1_n});
    check({32'd0, rd2_n});
    check(cnt_a);
    tick();

    // Reset with a simultaneous write to x9: no bypass, no write, no count.
    reset = 1'b1; reg_write = 1'b1; wr_idx = 5'd9; exe_data = 32'h55;
    rd_idx1 = 5'd9; rd_idx2 = 5'd3;
    expect_val("reset_no_bypass", 64'd0);
    expect_val("reset_stored_x3", 64'h2);
    expect_val("wbdata_in_reset", 64'h55);
    #1;
    check({32'd0, rd1_a});
    check({32'd0, rd2_a});
    check({32'd0, wbd_a});
    tick();
    reset = 1'b0; reg_write = 1'b0;
    expect_val("x9_after_reset", 64'd0);
    expect_val("x3_after_reset", 64'd0);
    expect_val("count_after_reset", 64'd0);
    #1;
    check({32'd0, rd1_a});
    check({32'd0, rd2_a});
    check(cnt_a);
    tick();

    // 17 commits to x1..x17: full counter reads 17, 4-bit counter wraps to 1.
    reg_write = 1'b1; mem_to_reg = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      wr_idx   = 5'(i);
      exe_data = 32'h1000 * 32'(i) + 32'(i);
      tick();
    end
    reg_write = 1'b0; rd_idx1 = 5'd1; rd_idx2 = 5'd17;
    expect_val("count_17", 64'd17);
    expect_val("count_c4_wrap", 64'd1);
    expect_val("x1_value", 64'h1001);
    expect_val("x17_value", 64'h11011);
    #1;
    check(cnt_a);
    check({60'd0, cnt_c});
    check({32'd0, rd1_a});
    check({32'd0, rd2_a});

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
